fp_mul_normalizer: RTL and testbench

- Post-processing stage directly downstream of the single-precision FP multiplier's mantissa datapath.
- Accepts both IEEE754 binary32 operands and the raw 48-bit significand product (1.mA × 1.mB).
- Produces the final correctly rounded binary32 product: normalization, round-to-nearest-even, exponent adjustment and special-value handling.
- Same start/done multi-cycle handshake style as the multiplier control unit.

---
 rtl/fp_mul_normalizer_if.sv | 40 ++++
 rtl/fp_mul_normalizer.sv | 211 +++++++++++++++++++++
 tb/tb_fp_mul_normalizer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fp_mul_normalizer_if.sv
// Handshake and data bundle between the FP multiplier datapath
// and its normalize/round/pack stage.
interface fp_mul_normalizer_if;
    logic        startNorm;
    logic [31:0] A;
    logic [31:0] B;
    logic [47:0] prod;
    logic [31:0] result;
    logic        doneNorm;
    logic        ovf;
    logic        unf;
    logic        invalid;
    logic        inexact;

    modport master (
        output startNorm,
        output A,
        output B,
        output prod,
        input  result,
        input  doneNorm,
        input  ovf,
        input  unf,
        input  invalid,
        input  inexact
    );

    modport slave (
        input  startNorm,
        input  A,
        input  B,
        input  prod,
        output result,
        output doneNorm,
        output ovf,
        output unf,
        output invalid,
        output inexact
    );
endinterface

// File: rtl/fp_mul_normalizer.sv
// Multi-cycle normalize / RNE round / pack stage that turns the raw
// significand product into a binary32 result with IEEE status flags.
module fp_mul_normalizer #(
    parameter int          BIAS = 127,
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input logic              clk,
    input logic              rst,
    fp_mul_normalizer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_NORM,
        S_ROUND,
        S_PACK
    } state_t;

    state_t state_q, state_d;

    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [47:0]        prod_q, prod_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [22:0]        frac_q, frac_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
    logic               nan_q, nan_d;
    logic               inf_q, inf_d;
    logic               zero_q, zero_d;

    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               invalid_q, invalid_d;
    logic               inexact_q, inexact_d;

    logic [7:0]         a_exp, b_exp;
    logic               a_frac_nz, b_frac_nz;
    logic               a_zero, b_zero;
    logic               a_inf, b_inf;
    logic               a_nan, b_nan;
    logic signed [9:0]  exp_sum;
    logic               round_inc;
    logic [23:0]        frac_rnd;

    assign a_exp     = a_q[30:23];
    assign b_exp     = b_q[30:23];
    assign a_frac_nz = |a_q[22:0];
    assign b_frac_nz = |b_q[22:0];

    // Exponent 0 means zero here: subnormal operands are flushed.
    assign a_zero = (a_exp == 8'h00);
    assign b_zero = (b_exp == 8'h00);
    assign a_inf  = (a_exp == 8'hFF) && !a_frac_nz;
    assign b_inf  = (b_exp == 8'hFF) && !b_frac_nz;
    assign a_nan  = (a_exp == 8'hFF) && a_frac_nz;
    assign b_nan  = (b_exp == 8'hFF) && b_frac_nz;

    assign exp_sum = $signed({2'b00, a_exp}
                           + {2'b00, b_exp}
                           - 10'(BIAS));

    assign round_inc = guard_q & (sticky_q | frac_q[0]);
    assign frac_rnd  = {1'b0, frac_q} + {23'd0, round_inc};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        prod_d    = prod_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        frac_d    = frac_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        nan_d     = nan_q;
        inf_d     = inf_q;
        zero_d    = zero_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        invalid_d = invalid_q;
        inexact_d = inexact_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.startNorm) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    prod_d  = bus.prod;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                sign_d  = a_q[31] ^ b_q[31];
                exp_d   = exp_sum;
                nan_d   = a_nan | b_nan
                        | (a_inf & b_zero)
                        | (b_inf & a_zero);
                inf_d   = a_inf | b_inf;
                zero_d  = a_zero | b_zero;
                state_d = S_NORM;
            end

            S_NORM: begin
                if (prod_q[47]) begin
                    frac_d   = prod_q[46:24];
                    guard_d  = prod_q[23];
                    sticky_d = |prod_q[22:0];
                    exp_d    = exp_q + 10'sd1;
                end else begin
                    frac_d   = prod_q[45:23];
                    guard_d  = prod_q[22];
                    sticky_d = |prod_q[21:0];
                end
                state_d = S_ROUND;
            end

            S_ROUND: begin
                if (frac_rnd[23]) begin
                    frac_d = 23'd0;
                    exp_d  = exp_q + 10'sd1;
                end else begin
                    frac_d = frac_rnd[22:0];
                end
                state_d = S_PACK;
            end

            S_PACK: begin
                ovf_d     = 1'b0;
                unf_d     = 1'b0;
                invalid_d = 1'b0;
                inexact_d = 1'b0;
                if (nan_q) begin
                    result_d  = QNAN;
                    invalid_d = 1'b1;
                end else if (inf_q) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                end else if (zero_q) begin
                    result_d = {sign_q, 31'd0};
                end else if (exp_q >= 10'sd255) begin
                    result_d  = {sign_q, 8'hFF, 23'd0};
                    ovf_d     = 1'b1;
                    inexact_d = 1'b1;
                end else if (exp_q <= 10'sd0) begin
                    result_d  = {sign_q, 31'd0};
                    unf_d     = 1'b1;
                    inexact_d = 1'b1;
                end else begin
                    result_d  = {sign_q, exp_q[7:0], frac_q};
                    inexact_d = guard_q | sticky_q;
                end
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            prod_q    <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            frac_q    <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            zero_q    <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            prod_q    <= prod_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            frac_q    <= frac_d;
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
            nan_q     <= nan_d;
            inf_q     <= inf_d;
            zero_q    <= zero_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            invalid_q <= invalid_d;
            inexact_q <= inexact_d;
        end
    end

    assign bus.doneNorm = (state_q == S_IDLE);
    assign bus.result   = result_q;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;
    assign bus.invalid  = invalid_q;
    assign bus.inexact  = inexact_q;

endmodule

// File: tb/tb_fp_mul_normalizer.sv
// Directed bench for fp_mul_normalizer: hand-computed products,
// rounding/overflow/underflow/special cases, reset and handshake.
module tb_fp_mul_normalizer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   busy;

    fp_mul_normalizer_if bus ();

    fp_mul_normalizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, bus.ovf, bus.unf, bus.invalid, bus.inexact};
    endfunction

    // Launch one op and count cycles with doneNorm low (bounded).
    task automatic do_op(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [47:0] p,
                         output int nbusy);
        @(negedge clk);
        bus.A         = a;
        bus.B         = b;
        bus.prod      = p;
        bus.startNorm = 1'b1;
        @(negedge clk);
        bus.startNorm = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.doneNorm) break;
            nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic op_chk(input string tag,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [47:0] p,
                          input logic [31:0] exp_res,
                          input logic [3:0]  exp_flg);
        int nb;
        do_op(a, b, p, nb);
        chk({tag, "_lat"}, 32'(nb), 32'd4);
        chk({tag, "_res"}, bus.result, exp_res);
        chk({tag, "_flg"}, flags(), {28'd0, exp_flg});
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bus.startNorm = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.prod      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        chk("rst_res",  bus.result, 32'h0);
        chk("rst_flg",  flags(), 32'h0);
        chk("rst_done", 32'(bus.doneNorm), 32'd1);

        // flags order: {ovf, unf, invalid, inexact}
        op_chk("one", 32'h3F800000, 32'h3F800000,
               48'h400000000000, 32'h3F800000, 4'b0000);

        // Abort in NORM: result must clear, never see the new op.
        @(negedge clk);
        bus.A         = 32'h3FC00000;
        bus.B         = 32'h3FC00000;
        bus.prod      = 48'h900000000000;
        bus.startNorm = 1'b1;
        @(negedge clk);
        bus.startNorm = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_res",  bus.result, 32'h0);
        chk("abort_flg",  flags(), 32'h0);
        chk("abort_done", 32'(bus.doneNorm), 32'd1);

        op_chk("norm1", 32'h3FC00000, 32'h3FC00000,
               48'h900000000000, 32'h40100000, 4'b0000);
        op_chk("tie", 32'h3F800001, 32'h3FC00000,
               48'h600000C00000, 32'h3FC00002, 4'b0001);
        op_chk("sticky", 32'h3F800001, 32'h3F800001,
               48'h400001000001, 32'h3F800002, 4'b0001);
        op_chk("rcarry", 32'h3F800000, 32'h3F800000,
               48'h7FFFFFC00000, 32'h40000000, 4'b0001);
        op_chk("ovf", 32'h7F000000, 32'h40000000,
               48'h400000000000, 32'h7F800000, 4'b1001);
        op_chk("unf", 32'h1F800000, 32'h1F800000,
               48'h400000000000, 32'h00000000, 4'b0101);
        op_chk("infx0", 32'h7F800000, 32'h00000000,
               48'h123456789ABC, 32'h7FC00000, 4'b0010);
        op_chk("nan", 32'h7F800001, 32'h3F800000,
               48'h400000000000, 32'h7FC00000, 4'b0010);
        op_chk("ninf", 32'hFF800000, 32'h40000000,
               48'h400000000000, 32'hFF800000, 4'b0000);
        op_chk("nzero", 32'h80000000, 32'h3F800000,
               48'h400000000000, 32'h80000000, 4'b0000);

        // Held start: back-to-back ops, 4 busy + 1 idle cycle each.
        @(negedge clk);
        bus.A         = 32'h3F800000;
        bus.B         = 32'h3F800000;
        bus.prod      = 48'h400000000000;
        bus.startNorm = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_done%0d", k),
                32'(bus.doneNorm), ((k % 5) == 4) ? 32'd1 : 32'd0);
            if ((k % 5) == 4)
                chk($sformatf("b2b_res%0d", k),
                    bus.result, 32'h3F800000);
        end
        bus.startNorm = 1'b0;
        @(negedge clk);
        chk("b2b_stop", 32'(bus.doneNorm), 32'd1);

        // Start pulse while in ROUND must not retrigger.
        @(negedge clk);
        bus.A         = 32'h3F800001;
        bus.B         = 32'h3FC00000;
        bus.prod      = 48'h600000C00000;
        bus.startNorm = 1'b1;
        @(negedge clk);
        bus.startNorm = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.startNorm = 1'b1;
        @(negedge clk);
        bus.startNorm = 1'b0;
        chk("pulse_busy", 32'(bus.doneNorm), 32'd0);
        @(negedge clk);
        chk("pulse_done", 32'(bus.doneNorm), 32'd1);
        chk("pulse_res",  bus.result, 32'h3FC00002);
        @(negedge clk);
        chk("pulse_idle", 32'(bus.doneNorm), 32'd1);

        busy = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
